// File: rtl/core_slot_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// core_slot_scheduler_pkg
//
// Shared definitions for the core slot scheduler:
//   - sched_state_t   : scheduler FSM states (IDLE waits for a packet head and
//                       makes the core/slot decision, PASS forwards the packet)
//   - DESC_*_LSB      : bit offsets of the fields inside a 64-bit descriptor.
//                       The core wrapper packs descriptors with the same
//                       offsets, so both sides must agree on them.
// ---------------------------------------------------------------------------
package core_slot_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } sched_state_t;

    localparam int DESC_LEN_LSB  = 0;
    localparam int DESC_SLOT_LSB = 16;
    localparam int DESC_PORT_LSB = 24;
    localparam int DESC_ADDR_LSB = 32;

endpackage

// File: rtl/core_slot_scheduler_rr_core_select.sv
// ---------------------------------------------------------------------------
// rr_core_select
//
// Round-robin selector over N requesters. The grant is the first eligible
// index strictly after the stored pointer, wrapping around. The pointer
// moves to the granted index only when 'update' is pulsed, so a grant that
// is not taken does not disturb fairness.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset (pointer <= N-1)
//   eligible     : per-requester eligibility vector
//   update       : load the pointer with the current grant
//   grant_idx    : index of the selected requester
//   grant_valid  : at least one requester is eligible
// ---------------------------------------------------------------------------
module rr_core_select #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] eligible,
    input  logic         update,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic [W-1:0] cand;

    // Walk the requesters starting just after the pointer; the first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(ptr_q) + i) % N);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        ptr_d = update ? grant_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/core_slot_scheduler.sv
// ---------------------------------------------------------------------------
// core_slot_scheduler
//
// Ingress scheduler in front of the cores' receive channels. For each packet
// it picks an enabled core that still has a free receive slot (round-robin),
// takes that core's lowest free slot, and forwards the packet with
// tdest = {core_id, slot}. Cores hand slots back by sending a descriptor on
// the control channel; the slot index sits at DESC_SLOT_LSB of the descriptor.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   s_axis_*              : ingress packets from the port switch (tuser = port)
//   m_axis_*              : egress to the cores; data/keep/last pass through,
//                           tdest/tuser are held for the whole packet
//   ctrl_s_axis_*         : sent-descriptors from the cores (tuser = core id)
//   core_enable           : per-core eligibility mask
//   slot_err              : sticky flag for out-of-range or duplicate frees
//   pkt_count/stall_count : statistics counters
//
// Build option SCHED_STATS_EN: when defined, pkt_count counts accepted tlast
// beats and stall_count counts IDLE cycles where a packet waits with no
// eligible core (both wrap). When undefined both outputs are tied to zero and
// no counter flops exist.
// ---------------------------------------------------------------------------
module core_slot_scheduler
    import core_slot_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int PORT_COUNT    = 4,
    parameter int PORT_WIDTH    = $clog2(PORT_COUNT),
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
    parameter int SLOT_COUNT    = 8,
    parameter int SLOT_WIDTH    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic [STRB_WIDTH-1:0]             s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [PORT_WIDTH-1:0]             s_axis_tuser,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [STRB_WIDTH-1:0]             m_axis_tkeep,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [CORE_ID_WIDTH+SLOT_WIDTH-1:0] m_axis_tdest,
    output logic [PORT_WIDTH-1:0]             m_axis_tuser,
    input  logic [63:0]                       ctrl_s_axis_tdata,
    input  logic                              ctrl_s_axis_tvalid,
    output logic                              ctrl_s_axis_tready,
    input  logic                              ctrl_s_axis_tlast,
    input  logic [CORE_ID_WIDTH-1:0]          ctrl_s_axis_tuser,
    input  logic [CORE_COUNT-1:0]             core_enable,
    output logic                              slot_err,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       stall_count
);

    localparam int SLOT_IDX_W = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

    sched_state_t                             state_q, state_d;
    logic [CORE_COUNT-1:0][SLOT_COUNT-1:0]    free_q, free_d;
    logic [CORE_ID_WIDTH-1:0]                 core_q, core_d;
    logic [SLOT_WIDTH-1:0]                    slot_q, slot_d;
    logic [PORT_WIDTH-1:0]                    port_q, port_d;
    logic                                     slot_err_q, slot_err_d;
    logic                                     ctrl_ready_q, ctrl_ready_d;

    logic [CORE_COUNT-1:0]                    eligible;
    logic [CORE_ID_WIDTH-1:0]                 grant_idx;
    logic                                     grant_valid;
    logic [SLOT_IDX_W-1:0]                    alloc_slot;
    logic                                     alloc;
    logic                                     stall;
    logic                                     pkt_done;

    logic [SLOT_WIDTH-1:0]                    ctrl_slot;
    logic [SLOT_IDX_W-1:0]                    ctrl_slot_idx;
    logic                                     free_oob;
    logic                                     unused_ctrl;

    assign ctrl_slot     = ctrl_s_axis_tdata[DESC_SLOT_LSB +: SLOT_WIDTH];
    assign ctrl_slot_idx = ctrl_slot[SLOT_IDX_W-1:0];
    assign free_oob      = (32'(ctrl_slot) >= SLOT_COUNT) ||
                           (32'(ctrl_s_axis_tuser) >= CORE_COUNT);
    assign unused_ctrl   = ^{ctrl_s_axis_tlast,
                             ctrl_s_axis_tdata[63:DESC_SLOT_LSB+SLOT_WIDTH],
                             ctrl_s_axis_tdata[DESC_SLOT_LSB-1:DESC_LEN_LSB]};

    // A core can take a packet only if it is enabled and has any free slot.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            eligible[c] = core_enable[c] & (|free_q[c]);
        end
    end

    rr_core_select #(
        .N (CORE_COUNT),
        .W (CORE_ID_WIDTH)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible),
        .update      (alloc),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next-state logic. The allocation and the free both look at free_q
    // (pre-update), so a slot returned this cycle is only grantable next
    // cycle. They can never touch the same bit: the allocated bit is set in
    // free_q, while a legal free targets a bit that is clear.
    always_comb begin
        state_d       = state_q;
        free_d        = free_q;
        core_d        = core_q;
        slot_d        = slot_q;
        port_d        = port_q;
        slot_err_d    = slot_err_q;
        ctrl_ready_d  = 1'b1;
        alloc         = 1'b0;
        stall         = 1'b0;
        pkt_done      = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;

        alloc_slot = '0;
        for (int s = SLOT_COUNT - 1; s >= 0; s--) begin
            if (free_q[grant_idx][s]) begin
                alloc_slot = SLOT_IDX_W'(s);
            end
        end

        case (state_q)
            ST_IDLE: begin
                // The head beat is held (tready=0) until the decision is made.
                if (s_axis_tvalid) begin
                    if (grant_valid) begin
                        alloc                         = 1'b1;
                        core_d                        = grant_idx;
                        slot_d                        = SLOT_WIDTH'(alloc_slot);
                        port_d                        = s_axis_tuser;
                        free_d[grant_idx][alloc_slot] = 1'b0;
                        state_d                       = ST_PASS;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_PASS: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    pkt_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_s_axis_tvalid && ctrl_ready_q) begin
            if (free_oob || free_q[ctrl_s_axis_tuser][ctrl_slot_idx]) begin
                slot_err_d = 1'b1;
            end else begin
                free_d[ctrl_s_axis_tuser][ctrl_slot_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            free_q       <= '1;
            core_q       <= '0;
            slot_q       <= '0;
            port_q       <= '0;
            slot_err_q   <= 1'b0;
            ctrl_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            free_q       <= free_d;
            core_q       <= core_d;
            slot_q       <= slot_d;
            port_q       <= port_d;
            slot_err_q   <= slot_err_d;
            ctrl_ready_q <= ctrl_ready_d;
        end
    end

    assign m_axis_tdata       = s_axis_tdata;
    assign m_axis_tkeep       = s_axis_tkeep;
    assign m_axis_tlast       = s_axis_tlast;
    assign m_axis_tdest       = {core_q, slot_q};
    assign m_axis_tuser       = port_q;
    assign slot_err           = slot_err_q;
    assign ctrl_s_axis_tready = ctrl_ready_q;

`ifdef SCHED_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        pkt_count_d   = pkt_count_q + 32'(pkt_done);
        stall_count_d = stall_count_q + 32'(stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            pkt_count_q   <= pkt_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_stats;
    assign unused_stats = pkt_done ^ stall;
    assign pkt_count    = '0;
    assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_core_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_core_slot_scheduler
//
// Self-checking bench for core_slot_scheduler with default parameters
// (16 cores, 8 slots, 8-bit slot field, 4 ports). A reference model keeps
// the free bitmap as plain arrays and replays the scheduling rules every
// cycle; directed sequences add explicit expected constants on top.
// ---------------------------------------------------------------------------
module tb_core_slot_scheduler;

    localparam int CC = 16;
    localparam int SC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [1:0]  s_tuser = '0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [11:0] m_tdest;
    logic [1:0]  m_tuser;
    logic [63:0] c_tdata = '0;
    logic        c_tvalid = 1'b0;
    logic        c_tready;
    logic        c_tlast = 1'b0;
    logic [3:0]  c_tuser = '0;
    logic [15:0] core_enable = '0;
    logic        slot_err;
    logic [31:0] pkt_count;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          free_m[CC][SC];
    int          ptr_m;
    bit          busy_m;
    int          core_m, slot_m, port_m;
    bit          err_m, cready_m;
    int unsigned pkt_m, stall_m;

    always #5 clk = ~clk;

    core_slot_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_tdata),
        .s_axis_tkeep       (s_tkeep),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .s_axis_tlast       (s_tlast),
        .s_axis_tuser       (s_tuser),
        .m_axis_tdata       (m_tdata),
        .m_axis_tkeep       (m_tkeep),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tlast       (m_tlast),
        .m_axis_tdest       (m_tdest),
        .m_axis_tuser       (m_tuser),
        .ctrl_s_axis_tdata  (c_tdata),
        .ctrl_s_axis_tvalid (c_tvalid),
        .ctrl_s_axis_tready (c_tready),
        .ctrl_s_axis_tlast  (c_tlast),
        .ctrl_s_axis_tuser  (c_tuser),
        .core_enable        (core_enable),
        .slot_err           (slot_err),
        .pkt_count          (pkt_count),
        .stall_count        (stall_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int c = 0; c < CC; c++)
            for (int s = 0; s < SC; s++)
                free_m[c][s] = 1'b1;
        ptr_m    = CC - 1;
        busy_m   = 1'b0;
        core_m   = 0;
        slot_m   = 0;
        port_m   = 0;
        err_m    = 1'b0;
        cready_m = 1'b0;
        pkt_m    = 0;
        stall_m  = 0;
    endtask

    function automatic bit anyFree(input int c);
        for (int s = 0; s < SC; s++)
            if (free_m[c][s]) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every DUT output with what the model predicts for this cycle.
    task automatic checkOutput();
        check("m_tvalid", m_tvalid, busy_m ? s_tvalid : 1'b0);
        check("s_tready", s_tready, busy_m ? m_tready : 1'b0);
        check("m_tdest", m_tdest, 64'(core_m * 256 + slot_m));
        check("m_tuser", m_tuser, 64'(port_m));
        check("slot_err", slot_err, err_m);
        check("ctrl_tready", c_tready, cready_m);
        if (busy_m && s_tvalid) begin
            check("m_tdata", m_tdata, s_tdata);
            check("m_tkeep", m_tkeep, s_tkeep);
            check("m_tlast", m_tlast, s_tlast);
        end
`ifdef SCHED_STATS_EN
        check("pkt_count", pkt_count, pkt_m);
        check("stall_count", stall_count, stall_m);
`else
        check("pkt_count", pkt_count, 0);
        check("stall_count", stall_count, 0);
`endif
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic updateModel();
        int gc = -1;
        int gs = -1;
        if (rst) begin
            resetModel();
            return;
        end
        if (!busy_m && s_tvalid) begin
            for (int k = 1; k <= CC; k++) begin
                int c;
                c = (ptr_m + k) % CC;
                if (gc < 0 && core_enable[c] && anyFree(c)) gc = c;
            end
            if (gc >= 0) begin
                for (int s = SC - 1; s >= 0; s--)
                    if (free_m[gc][s]) gs = s;
            end else begin
                stall_m++;
            end
        end else if (busy_m && s_tvalid && m_tready && s_tlast) begin
            busy_m = 1'b0;
            pkt_m++;
        end
        if (cready_m && c_tvalid) begin
            int fc;
            int fs;
            fc = int'(c_tuser);
            fs = int'(c_tdata[23:16]);
            if (fs >= SC || free_m[fc][fs]) err_m = 1'b1;
            else free_m[fc][fs] = 1'b1;
        end
        if (gc >= 0) begin
            free_m[gc][gs] = 1'b0;
            busy_m = 1'b1;
            core_m = gc;
            slot_m = gs;
            port_m = int'(s_tuser);
            ptr_m  = gc;
        end
        cready_m = 1'b1;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic cycle();
        applyStimulus();
        endCycle();
    endtask

    task automatic doReset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        c_tvalid = 1'b0;
        endCycle();
        endCycle();
        rst = 1'b0;
    endtask

    task automatic sendFree(input int core, input int slot);
        c_tvalid = 1'b1;
        c_tuser  = 4'(core);
        c_tdata  = 64'(slot) << 16;
        cycle();
        c_tvalid = 1'b0;
    endtask

    typedef struct {
        logic        sv;
        logic        mr;
        logic        exp_mv;
        logic        exp_sr;
        logic [11:0] exp_dest;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int got;
        int accepted;
        int k;
        logic [63:0] beats[4];

        // Cores 0 and 1, three single-beat packets: 0x000, 0x100, 0x001.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h100};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h100};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h001};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h001};

        resetModel();
        doReset();
        core_enable = 16'h0003;
        s_tlast     = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = tbl[i].sv;
            m_tready = tbl[i].mr;
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = 8'($urandom);
            s_tuser  = 2'(i);
            applyStimulus();
            check("tbl_mvalid", m_tvalid, tbl[i].exp_mv);
            check("tbl_sready", s_tready, tbl[i].exp_sr);
            check("tbl_dest", m_tdest, tbl[i].exp_dest);
            if (i == 0) check("tbl_reset_err", slot_err, 1'b0);
            endCycle();
        end

        // Core 0 only: eight packets fill slots 0..7, the ninth must wait.
        doReset();
        core_enable = 16'h0001;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            applyStimulus();
            if (m_tvalid && m_tready) begin
                check("fill_dest", m_tdest, 64'(got));
                got++;
            end
            endCycle();
        end
        check("fill_count", got, 8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            check("hold_sready", s_tready, 1'b0);
            check("hold_mvalid", m_tvalid, 1'b0);
            endCycle();
        end
        sendFree(0, 5);
        applyStimulus();
        check("after_free_idle", s_tready, 1'b0);
        endCycle();
        applyStimulus();
        check("after_free_mvalid", m_tvalid, 1'b1);
        check("after_free_dest", m_tdest, 12'h005);
        endCycle();
        s_tvalid = 1'b0;
        cycle();

        // Free and allocate on core 0 in the same cycle.
        doReset();
        core_enable = 16'h0001;
        s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        c_tvalid = 1'b1;
        c_tuser  = 4'd0;
        c_tdata  = 64'(0) << 16;
        cycle();
        c_tvalid = 1'b0;
        applyStimulus();
        check("same_cycle_old_state", m_tdest, 12'h002);
        endCycle();
        cycle();
        applyStimulus();
        check("freed_reused_next", m_tdest, 12'h000);
        endCycle();
        s_tvalid = 1'b0;
        cycle();

        // Duplicate free of an already-free slot sets the sticky error.
        doReset();
        cycle();
        sendFree(2, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            check("dup_free_err", slot_err, 1'b1);
            endCycle();
        end

        // Out-of-range slot 9 must not alias onto slot 1 of core 2.
        doReset();
        core_enable = 16'h0004;
        s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        s_tvalid = 1'b0;
        sendFree(2, 9);
        applyStimulus();
        check("oob_free_err", slot_err, 1'b1);
        endCycle();
        s_tvalid = 1'b1;
        cycle();
        applyStimulus();
        check("oob_no_alias_dest", m_tdest, 12'h202);
        check("oob_err_sticky", slot_err, 1'b1);
        endCycle();
        s_tvalid = 1'b0;
        cycle();

        // Four-beat packet with egress ready toggling 1,0,1,0,...
        doReset();
        core_enable = 16'h0010;
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        s_tvalid = 1'b1;
        s_tdata  = beats[0];
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        cycle();
        accepted = 0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            s_tdata  = beats[k];
            s_tlast  = (k == 3);
            m_tready = (c % 2 == 0);
            applyStimulus();
            check("burst_dest", m_tdest, 12'h400);
            if (m_tvalid && m_tready) begin
                check("burst_data", m_tdata, beats[k]);
                accepted++;
            end
            endCycle();
            if (m_tready) k++;
        end
        check("burst_beats", accepted, 4);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        applyStimulus();
        check("burst_back_idle", s_tready, 1'b0);
        endCycle();

        // Statistics: three blocked cycles, then five packets.
        doReset();
        core_enable = 16'h0000;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        core_enable = 16'h0001;
        for (int i = 0; i < 10; i++) cycle();
        s_tvalid = 1'b0;
        applyStimulus();
`ifdef SCHED_STATS_EN
        check("stats_pkt", pkt_count, 5);
        check("stats_stall", stall_count, 3);
`else
        check("stats_pkt_off", pkt_count, 0);
        check("stats_stall_off", stall_count, 0);
`endif
        endCycle();

        // Randomised traffic against the model, with rare resets.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            core_enable = 16'($urandom) | 16'($urandom);
            s_tvalid    = ($urandom_range(0, 3) != 0);
            s_tlast     = ($urandom_range(0, 2) == 0);
            s_tdata     = {$urandom, $urandom};
            s_tkeep     = 8'($urandom);
            s_tuser     = 2'($urandom);
            m_tready    = ($urandom_range(0, 3) != 0);
            c_tvalid    = ($urandom_range(0, 3) == 0);
            c_tuser     = 4'($urandom);
            c_tdata     = {$urandom, $urandom};
            c_tdata[23:16] = 8'($urandom_range(0, 9));
            c_tlast     = 1'($urandom);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
